psync_hs: RTL and testbench

Multi-channel, handshaked pulse synchronizer. It carries `N` independent pulse streams from `in_clk` to `out_clk`. Each channel buffers pulses that arrive while a transfer is in flight and replays them, up to `MAX_PEND` per channel. It is the general-purpose successor to the single-channel toggle synchronizer and is used wherever pulses may arrive back-to-back or faster than a crossing round trip.

---
 rtl/psync_hs_pkg.sv | 11 +
 rtl/psync_hs_chan.sv | 107 ++++++++++
 rtl/psync_hs.sv | 45 ++++
 tb/tb_psync_hs.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/psync_hs_pkg.sv
// rtl/psync_hs_pkg.sv - shared constants and sizing helper for the handshaked pulse synchronizer
package rz_psync_pkg;

    localparam int PSYNC_MIN_STAGES = 2;

    // Width of a pending counter able to hold 0..max_pend
    function automatic int pend_w(input int max_pend);
        return (max_pend < 1) ? 1 : $clog2(max_pend + 1);
    endfunction

endpackage

// File: rtl/psync_hs_chan.sv
// rtl/psync_hs_chan.sv - one channel: toggle req/ack handshake with pending-pulse counter
// Optional sticky overflow flag under RZ_LIB_PSYNC_OVF_EN.
module psync_hs_chan
    import rz_psync_pkg::*;
#(
    parameter int MAX_PEND    = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic in_clk,
    input  logic in_reset_n,
    input  logic out_clk,
    input  logic out_reset_n,
    input  logic in_pulse,
    input  logic ovf_clr,
    output logic out_pulse,
    output logic busy,
    output logic ovf
);

    localparam int PW = pend_w(MAX_PEND);
    localparam logic [PW:0] MAX_E = (PW+1)'(MAX_PEND);
    localparam logic [PW:0] ONE_E = (PW+1)'(1);

    logic                   req_q, req_d;
    logic [PW-1:0]          cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
    logic                   req_hist_q, req_hist_d;
    logic                   ack_s;
    logic                   inflight;
    logic                   drop;
    logic [PW:0]            e;

    always_comb begin
        ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], req_hist_q};
        ack_s      = ack_sync_q[SYNC_STAGES-1];
        inflight   = req_q ^ ack_s;
        e          = {1'b0, cnt_q} + {{PW{1'b0}}, in_pulse};
        req_d      = req_q;
        cnt_d      = cnt_q;
        drop       = 1'b0;
        if (!inflight && (e != '0)) begin
            req_d = ~req_q;
            cnt_d = PW'(e - ONE_E);
        end else if (e <= MAX_E) begin
            cnt_d = PW'(e);
        end else begin
            // counter full and a transfer still in flight: the pulse is lost
            drop = 1'b1;
        end
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            req_q      <= 1'b0;
            cnt_q      <= '0;
            ack_sync_q <= '0;
        end else begin
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            ack_sync_q <= ack_sync_d;
        end
    end

    assign busy = inflight | (cnt_q != '0);

`ifdef RZ_LIB_PSYNC_OVF_EN
    logic ovf_q, ovf_d;

    // a drop on the same edge as a clear keeps the flag set
    always_comb begin
        ovf_d = drop | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_inputs;
    assign unused_ovf_inputs = ovf_clr ^ drop;
    assign ovf = 1'b0;
`endif

    always_comb begin
        req_sync_d = {req_sync_q[SYNC_STAGES-2:0], req_q};
        req_hist_d = req_sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge out_clk or negedge out_reset_n) begin
        if (!out_reset_n) begin
            req_sync_q <= '0;
            req_hist_q <= 1'b0;
        end else begin
            req_sync_q <= req_sync_d;
            req_hist_q <= req_hist_d;
        end
    end

    assign out_pulse = req_sync_q[SYNC_STAGES-1] ^ req_hist_q;

endmodule

// File: rtl/psync_hs.sv
// rtl/psync_hs.sv - N-channel handshaked pulse synchronizer, in_clk to out_clk
// Overflow flags are live only when RZ_LIB_PSYNC_OVF_EN is defined.
module psync_hs
    import rz_psync_pkg::*;
#(
    parameter int N           = 1,
    parameter int MAX_PEND    = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic         in_clk,
    input  logic         in_reset_n,
    input  logic         out_clk,
    input  logic         out_reset_n,
    input  logic [N-1:0] in,
    output logic [N-1:0] out,
    output logic [N-1:0] busy,
    output logic [N-1:0] ovf,
    input  logic [N-1:0] ovf_clr
);

    if (SYNC_STAGES < PSYNC_MIN_STAGES) begin : g_bad_stages
        $error("psync_hs: SYNC_STAGES must be at least %0d", PSYNC_MIN_STAGES);
    end
    if (MAX_PEND < 1) begin : g_bad_pend
        $error("psync_hs: MAX_PEND must be at least 1");
    end

    for (genvar i = 0; i < N; i++) begin : g_chan
        psync_hs_chan #(
            .MAX_PEND   (MAX_PEND),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_chan (
            .in_clk     (in_clk),
            .in_reset_n (in_reset_n),
            .out_clk    (out_clk),
            .out_reset_n(out_reset_n),
            .in_pulse   (in[i]),
            .ovf_clr    (ovf_clr[i]),
            .out_pulse  (out[i]),
            .busy       (busy[i]),
            .ovf        (ovf[i])
        );
    end

endmodule

// File: tb/tb_psync_hs.sv
// tb/tb_psync_hs.sv - scoreboard bench for psync_hs (4 channels, MAX_PEND=3, 2 sync stages)
`timescale 1ns/1ps
module tb_psync_hs;

    localparam int N = 4;
`ifdef RZ_LIB_PSYNC_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic         in_clk = 1'b0;
    logic         out_clk = 1'b0;
    logic         in_reset_n;
    logic         out_reset_n;
    logic [N-1:0] in_p;
    logic [N-1:0] out_p;
    logic [N-1:0] busy;
    logic [N-1:0] ovf;
    logic [N-1:0] ovf_clr;

    real out_half = 13.5;
    int  total = 0;
    int  bad = 0;
    int  tag = 0;
    int  exp_q [N][$];

    psync_hs #(.N(N), .MAX_PEND(3), .SYNC_STAGES(2)) dut (
        .in_clk     (in_clk),
        .in_reset_n (in_reset_n),
        .out_clk    (out_clk),
        .out_reset_n(out_reset_n),
        .in         (in_p),
        .out        (out_p),
        .busy       (busy),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    always #5 in_clk = ~in_clk;
    always #(out_half) out_clk = ~out_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every out pulse must consume one expected event of its channel
    always @(negedge out_clk) begin
        for (int i = 0; i < N; i++) begin
            if (out_p[i] === 1'b1) begin
                total++;
                if (exp_q[i].size() == 0) begin
                    bad++;
                    $display("FAIL out_unexpected ch%0d: got pulse expected none", i);
                end else begin
                    void'(exp_q[i].pop_front());
                end
            end
        end
    end

    function automatic int qsum();
        int s = 0;
        for (int i = 0; i < N; i++) s += exp_q[i].size();
        return s;
    endfunction

    // Present one in_clk cycle of stimulus; keep marks pulses expected to be delivered
    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] keep, input logic [N-1:0] clr);
        @(negedge in_clk);
        in_p    = v;
        ovf_clr = clr;
        for (int i = 0; i < N; i++) begin
            if (keep[i]) begin
                exp_q[i].push_back(tag);
                tag++;
            end
        end
    endtask

    task automatic idle();
        drive('0, '0, '0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (((busy !== '0) || (qsum() != 0)) && (n < 3000)) begin
            @(negedge in_clk);
            n++;
        end
        repeat (10) @(negedge out_clk);
        check({name, "_settled"}, 32'(n < 3000), 32'd1);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_missing_ch%0d", name, i), 32'(exp_q[i].size()), 32'd0);
            exp_q[i].delete();
        end
        check({name, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        in_reset_n  = 1'b0;
        out_reset_n = 1'b0;
        in_p        = '0;
        ovf_clr     = '0;
        repeat (4) @(negedge out_clk);
        check("reset_out", 32'(out_p), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        @(negedge in_clk);
        in_reset_n  = 1'b1;
        out_reset_n = 1'b1;
        repeat (3) @(negedge in_clk);

        // single pulse at 37 MHz out_clk, latency counted from the launch edge
        drive(4'b0001, 4'b0001, '0);
        @(posedge in_clk);
        #1 in_p = '0;
        check("single_busy_set", 32'(busy[0]), 32'd1);
        k = 0;
        do begin
            @(posedge out_clk);
            #1 k++;
        end while ((out_p[0] !== 1'b1) && (k < 10));
        check("single_latency_ok", 32'((k >= 2) && (k <= 4)), 32'd1);
        drain("single");
        check("single_ovf", 32'(ovf), 32'd0);

        // burst of three within MAX_PEND
        drive(4'b0001, 4'b0001, '0);
        drive(4'b0001, 4'b0001, '0);
        drive(4'b0001, 4'b0001, '0);
        idle();
        check("burst_busy", 32'(busy[0]), 32'd1);
        drain("burst");
        check("burst_ovf", 32'(ovf), 32'd0);

        // overflow: five back-to-back, fifth dropped
        for (int j = 0; j < 4; j++) drive(4'b0001, 4'b0001, '0);
        drive(4'b0001, 4'b0000, '0);
        idle();
        check("ovf_set", 32'(ovf), 32'(OVF_ON));
        drain("ovf");
        check("ovf_sticky", 32'(ovf), 32'(OVF_ON));
        drive('0, '0, 4'b0001);
        idle();
        check("ovf_cleared", 32'(ovf), 32'd0);

        // clear coincides with the dropping edge
        for (int j = 0; j < 4; j++) drive(4'b0001, 4'b0001, '0);
        drive(4'b0001, 4'b0000, 4'b0001);
        idle();
        check("collide_ovf", 32'(ovf), 32'(OVF_ON));
        drain("collide");
        drive('0, '0, 4'b1111);
        idle();
        check("collide_cleared", 32'(ovf), 32'd0);

        // fast out_clk: simultaneous pulses and mixed bursts, at most 4 per channel
        out_half = 2.0;
        repeat (4) @(negedge in_clk);
        drive(4'b1111, 4'b1111, '0);
        idle();
        drain("fast_all");
        drive(4'b1111, 4'b1111, '0);
        drive(4'b1110, 4'b1110, '0);
        drive(4'b1100, 4'b1100, '0);
        drive(4'b1000, 4'b1000, '0);
        idle();
        drain("fast_stair");
        drive(4'b0101, 4'b0101, '0);
        drive(4'b1010, 4'b1010, '0);
        idle();
        drive(4'b0110, 4'b0110, '0);
        drive(4'b1001, 4'b1001, '0);
        idle();
        drain("fast_mix");
        check("fast_ovf", 32'(ovf), 32'd0);

        // slow out_clk: five on every channel, each loses one
        out_half = 50.0;
        repeat (4) @(negedge in_clk);
        for (int j = 0; j < 4; j++) drive(4'b1111, 4'b1111, '0);
        drive(4'b1111, 4'b0000, '0);
        idle();
        check("slow_ovf", 32'(ovf), OVF_ON ? 32'hf : 32'd0);
        drain("slow_all");
        drive(4'b0011, 4'b0011, '0);
        drive(4'b0010, 4'b0010, '0);
        idle();
        drain("slow_mix");
        drive('0, '0, 4'b1111);
        idle();
        check("slow_ovf_cleared", 32'(ovf), 32'd0);

        // reset two in_clk cycles after launch; the event must vanish
        out_half = 13.5;
        repeat (4) @(negedge in_clk);
        drive(4'b0001, 4'b0000, '0);
        @(posedge in_clk);
        #1 in_p = '0;
        repeat (2) @(posedge in_clk);
        #1;
        in_reset_n  = 1'b0;
        out_reset_n = 1'b0;
        repeat (3) @(negedge out_clk);
        check("midrst_out", 32'(out_p), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        @(negedge in_clk);
        in_reset_n  = 1'b1;
        out_reset_n = 1'b1;
        repeat (20) @(negedge out_clk);
        check("midrst_busy_after", 32'(busy), 32'd0);
        check("midrst_no_out", 32'(qsum()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
